// File: rtl/homenc_pkg.sv
// Shared constants, derived sizes and FSM encoding for the homomorphic-add sequencer.
package homenc_pkg;

    localparam int DEF_CIPHERTEXT_WIDTH = 10;
    localparam int DEF_DIMENSION        = 1;

    // Index register width for a vector of len words (never narrower than 1 bit).
    function automatic int idx_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    localparam int DEF_LEN   = DEF_DIMENSION + 1;
    localparam int DEF_IDX_W = idx_width(DEF_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_e;

endpackage

// File: rtl/homomorphic_add.sv
// Element-wise LWE ciphertext word adder; the result is reduced modulo 2^WIDTH.
module homomorphic_add
    import homenc_pkg::*;
#(
    parameter int WIDTH = DEF_CIPHERTEXT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // The carry out of the top bit is dropped, which is exactly the modular reduction.
    assign sum = a + b;

endmodule

// File: rtl/homomorphic_add_ctrl.sv
// Sequencer that reads two ciphertext vectors from shared memory, adds them word by
// word through homomorphic_add and writes the sums to a destination vector.
module homomorphic_add_ctrl
    import homenc_pkg::*;
#(
    parameter int CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int DIMENSION          = DEF_DIMENSION,
    parameter int ADDR_WIDTH         = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       src1_base,
    input  logic [ADDR_WIDTH-1:0]       src2_base,
    input  logic [ADDR_WIDTH-1:0]       dst_base,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [CIPHERTEXT_WIDTH-1:0] mem_wdata,
    input  logic                        mem_gnt,
    input  logic [CIPHERTEXT_WIDTH-1:0] mem_rdata
);

    localparam int LEN   = DIMENSION + 1;
    localparam int IDX_W = idx_width(LEN);
    localparam int MOD_W = $clog2(CIPHERTEXT_MODULUS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]       src1_q, src1_d;
    logic [ADDR_WIDTH-1:0]       src2_q, src2_d;
    logic [ADDR_WIDTH-1:0]       dst_q, dst_d;
    logic [CIPHERTEXT_WIDTH-1:0] op1_q, op1_d;
    logic [CIPHERTEXT_WIDTH-1:0] op2_q, op2_d;
    logic                        rvalid_q, rvalid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        mem_req_q, mem_req_d;
    logic                        mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
    logic [CIPHERTEXT_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [CIPHERTEXT_WIDTH-1:0] sum;
    logic                        granted;

    // The adder sees op2_d so the sum is ready on the same edge that enters WR.
    homomorphic_add #(
        .WIDTH (MOD_W)
    ) u_add (
        .a   (op1_q),
        .b   (op2_d),
        .sum (sum)
    );

    assign granted  = mem_req_q & mem_gnt;
    assign rvalid_d = mem_req_q & mem_gnt & ~mem_we_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dst_d       = dst_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD1;
                    idx_d   = '0;
                    src1_d  = src1_base;
                    src2_d  = src2_base;
                    dst_d   = dst_base;
                end
            end
            S_RD1: begin
                if (granted) state_d = S_RD2;
            end
            S_RD2: begin
                if (rvalid_q) op1_d = mem_rdata;
                if (granted) state_d = S_CAP;
            end
            S_CAP: begin
                op2_d   = mem_rdata;
                state_d = S_WR;
            end
            S_WR: begin
                if (granted) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        unique case (state_d)
            S_RD1: begin
                mem_req_d  = 1'b1;
                mem_addr_d = src1_d + ADDR_WIDTH'(idx_d);
            end
            S_RD2: begin
                mem_req_d  = 1'b1;
                mem_addr_d = src2_d + ADDR_WIDTH'(idx_d);
            end
            S_WR: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = dst_d + ADDR_WIDTH'(idx_d);
                mem_wdata_d = sum;
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dst_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dst_q       <= dst_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_homomorphic_add_ctrl.sv
// Scoreboard bench for homomorphic_add_ctrl: directed ops push expected memory events,
// a monitor pops and compares them as the DUT issues granted accesses and done.
module tb_homomorphic_add_ctrl;

    localparam int AW = 8;
    localparam int CW = 10;
    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [9:0]  data;
        int          cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src1_base, src2_base, dst_base;
    logic          busy, done;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    logic          mem_gnt;
    logic [CW-1:0] mem_rdata;

    logic [CW-1:0] mem [0:255];
    exp_t          sb[$];
    exp_t          mon_e;
    int            mon_kind;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            c0      = 0;

    homomorphic_add_ctrl #(
        .CIPHERTEXT_WIDTH   (CW),
        .CIPHERTEXT_MODULUS (1024),
        .DIMENSION          (1),
        .ADDR_WIDTH         (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src1_base (src1_base),
        .src2_base (src2_base),
        .dst_base  (dst_base),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Memory model: read data one cycle after a granted read, junk otherwise.
    always @(posedge clk) begin
        if (mem_req && mem_gnt && mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_req && mem_gnt && !mem_we) ? mem[mem_addr] : 10'h2A5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_rd(input logic [7:0] a);
        exp_t e;
        e.kind = K_RD; e.addr = a; e.data = '0; e.cyc = 0;
        sb.push_back(e);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [9:0] d);
        exp_t e;
        e.kind = K_WR; e.addr = a; e.data = d; e.cyc = 0;
        sb.push_back(e);
    endtask

    task automatic push_done(input int rel_cyc);
        exp_t e;
        e.kind = K_DONE; e.addr = '0; e.data = '0; e.cyc = rel_cyc;
        sb.push_back(e);
    endtask

    // Monitor: every granted access or done pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_kind = -1;
            if (mem_req && mem_gnt) mon_kind = mem_we ? K_WR : K_RD;
            else if (done)          mon_kind = K_DONE;
            if (mon_kind >= 0) begin
                check("sb_has_item", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("ev_kind", 32'(mon_kind), 32'(mon_e.kind));
                    if (mon_kind == K_DONE) check("done_cycle", 32'(cyc - c0), 32'(mon_e.cyc));
                    else                    check("ev_addr", 32'(mem_addr), 32'(mon_e.addr));
                    if (mon_kind == K_WR)   check("ev_wdata", 32'(mem_wdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] d);
        next_cycle();
        start     = 1'b1;
        src1_base = s1;
        src2_base = s2;
        dst_base  = d;
        c0        = cyc;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 32'(done), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // Outputs must not move for n consecutive stalled cycles.
    task automatic hold_check(input int n, input string tag);
        logic          r, w;
        logic [AW-1:0] a;
        logic [CW-1:0] d;
        @(negedge clk);
        r = mem_req; w = mem_we; a = mem_addr; d = mem_wdata;
        for (int i = 1; i < n; i++) begin
            next_cycle();
            @(negedge clk);
            check({tag, "_req"},   32'(mem_req),   32'(r));
            check({tag, "_we"},    32'(mem_we),    32'(w));
            check({tag, "_addr"},  32'(mem_addr),  32'(a));
            check({tag, "_wdata"}, 32'(mem_wdata), 32'(d));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_req"},   32'(mem_req),   32'd0);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_gnt = 1'b1;
        src1_base = '0; src2_base = '0; dst_base = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 10'd100; mem[8'h11] = 10'd900;
        mem[8'h20] = 10'd200; mem[8'h21] = 10'd300;
        #3;
        check_outputs_zero("reset");
        #9 rst_n = 1'b1;

        // Basic add with continuous grant; busy must cover cycles 1..9.
        push_rd(8'h10); push_rd(8'h20); push_wr(8'h30, 10'd300);
        push_rd(8'h11); push_rd(8'h21); push_wr(8'h31, 10'd176);
        push_done(9);
        start_op(8'h10, 8'h20, 8'h30);
        check("basic_busy_c0", 32'(busy), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            start = 1'b0;
            check($sformatf("basic_busy_c%0d", k), 32'(busy), 32'(k <= 9));
        end
        check("basic_drained", 32'(sb.size()), 32'd0);
        check("basic_mem30", 32'(mem[8'h30]), 32'd300);
        check("basic_mem31", 32'(mem[8'h31]), 32'd176);

        // Grant stalls: 3 cycles in RD2 and 2 in WR of element 0.
        push_rd(8'h10); push_rd(8'h20); push_wr(8'h38, 10'd300);
        push_rd(8'h11); push_rd(8'h21); push_wr(8'h39, 10'd176);
        push_done(14);
        start_op(8'h10, 8'h20, 8'h38);
        next_cycle(); start = 1'b0;
        next_cycle(); mem_gnt = 1'b0;
        check("stall_rd2_addr", 32'(mem_addr), 32'h20);
        hold_check(3, "stall_rd2");
        next_cycle(); mem_gnt = 1'b1;
        next_cycle();
        next_cycle(); mem_gnt = 1'b0;
        check("stall_wr_we", 32'(mem_we), 32'd1);
        check("stall_wr_wdata", 32'(mem_wdata), 32'd300);
        hold_check(2, "stall_wr");
        next_cycle(); mem_gnt = 1'b1;
        wait_done(20);
        check("stall_mem39", 32'(mem[8'h39]), 32'd176);

        // Address wrap: src1 and dst start at 0xFF and continue at 0x00.
        mem[8'hFF] = 10'd5; mem[8'h00] = 10'd1000;
        mem[8'h50] = 10'd7; mem[8'h51] = 10'd30;
        push_rd(8'hFF); push_rd(8'h50); push_wr(8'hFF, 10'd12);
        push_rd(8'h00); push_rd(8'h51); push_wr(8'h00, 10'd6);
        push_done(9);
        start_op(8'hFF, 8'h50, 8'hFF);
        next_cycle(); start = 1'b0;
        wait_done(20);
        next_cycle();
        check("wrap_memFF", 32'(mem[8'hFF]), 32'd12);
        check("wrap_mem00", 32'(mem[8'h00]), 32'd6);

        // In-place add: dst == src1.
        mem[8'h40] = 10'd1023; mem[8'h41] = 10'd1;
        mem[8'h48] = 10'd1;    mem[8'h49] = 10'd1;
        push_rd(8'h40); push_rd(8'h48); push_wr(8'h40, 10'd0);
        push_rd(8'h41); push_rd(8'h49); push_wr(8'h41, 10'd2);
        push_done(9);
        start_op(8'h40, 8'h48, 8'h40);
        next_cycle(); start = 1'b0;
        wait_done(20);
        next_cycle();
        check("inplace_mem40", 32'(mem[8'h40]), 32'd0);
        check("inplace_mem41", 32'(mem[8'h41]), 32'd2);

        // start during RD2 and DONE, plus base changes mid-op, must all be ignored.
        mem[8'h60] = 10'd10; mem[8'h61] = 10'd20;
        mem[8'h70] = 10'd3;  mem[8'h71] = 10'd4;
        push_rd(8'h60); push_rd(8'h70); push_wr(8'h80, 10'd13);
        push_rd(8'h61); push_rd(8'h71); push_wr(8'h81, 10'd24);
        push_done(9);
        start_op(8'h60, 8'h70, 8'h80);
        next_cycle(); start = 1'b0;
        src1_base = 8'hEE; src2_base = 8'hEE; dst_base = 8'hEE;
        next_cycle(); start = 1'b1;
        src1_base = 8'h90; src2_base = 8'hA0; dst_base = 8'hB0;
        next_cycle(); start = 1'b0;
        repeat (6) next_cycle();
        check("ign_done_c9", 32'(done), 32'd1);
        start = 1'b1;
        src1_base = 8'hC0; src2_base = 8'hC8; dst_base = 8'hD8;
        next_cycle(); start = 1'b0;
        repeat (6) next_cycle();
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("ign_drained", 32'(sb.size()), 32'd0);
        check("ign_mem81", 32'(mem[8'h81]), 32'd24);

        // Reset in WR of element 1 before grant: that write must never happen.
        mem[8'hC1] = 10'h155;
        push_rd(8'h10); push_rd(8'h20); push_wr(8'hC0, 10'd300);
        push_rd(8'h11); push_rd(8'h21);
        start_op(8'h10, 8'h20, 8'hC0);
        next_cycle(); start = 1'b0;
        repeat (6) next_cycle();
        next_cycle(); mem_gnt = 1'b0;
        check("rst_pre_we", 32'(mem_we), 32'd1);
        check("rst_pre_addr", 32'(mem_addr), 32'hC1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        next_cycle();
        next_cycle(); rst_n = 1'b1; mem_gnt = 1'b1;
        check("midrst_drained", 32'(sb.size()), 32'd0);
        check("midrst_memC1", 32'(mem[8'hC1]), 32'h155);
        push_rd(8'h10); push_rd(8'h20); push_wr(8'hD0, 10'd300);
        push_rd(8'h11); push_rd(8'h21); push_wr(8'hD1, 10'd176);
        push_done(9);
        start_op(8'h10, 8'h20, 8'hD0);
        next_cycle(); start = 1'b0;
        wait_done(20);
        next_cycle();
        check("post_rst_memD1", 32'(mem[8'hD1]), 32'd176);
        check("post_rst_memC1", 32'(mem[8'hC1]), 32'h155);

        repeat (3) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
